// File: rtl/washer_btn_conditioner.sv
// Push-button front end: 2-flop sync, per-channel debounce, then registered
// press/release edges and long-press/auto-repeat pulses from a hold counter.
module washer_btn_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 200,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 5'b10000
) (
  input  logic             clk,
  input  logic             in_reset,
  input  logic [N_BTN-1:0] in_btn,
  output logic [N_BTN-1:0] out_level,
  output logic [N_BTN-1:0] out_press,
  output logic [N_BTN-1:0] out_release,
  output logic [N_BTN-1:0] out_long,
  output logic [N_BTN-1:0] out_repeat
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_CYCLES - REPEAT_CYCLES);

  logic [N_BTN-1:0]  sync1, sync2;
  logic [DB_W-1:0]   dbCnt       [N_BTN];
  logic [DB_W-1:0]   dbCntNext   [N_BTN];
  logic [HOLD_W-1:0] holdCnt     [N_BTN];
  logic [HOLD_W-1:0] holdCntNext [N_BTN];
  logic [N_BTN-1:0]  levelNext;
  logic [N_BTN-1:0]  longSeen, longSeenNext;
  logic [N_BTN-1:0]  hit;

  always_comb begin
    levelNext    = out_level;
    longSeenNext = '0;
    hit          = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      dbCntNext[i]   = '0;
      holdCntNext[i] = '0;

      if (sync2[i] != out_level[i]) begin
        if (dbCnt[i] == DB_LAST) levelNext[i] = ~out_level[i];
        else                     dbCntNext[i] = dbCnt[i] + DB_W'(1);
      end

      // Hold count is keyed on the next level so a release cuts it off in the
      // same edge, and the press cycle itself always shows a count of zero.
      if (levelNext[i] && out_level[i]) begin
        if (holdCnt[i] != HOLD_LAST) holdCntNext[i] = holdCnt[i] + HOLD_W'(1);
        else if (REPEAT_MASK[i])     holdCntNext[i] = HOLD_RELOAD;
        else                         holdCntNext[i] = HOLD_LAST;
      end

      hit[i] = levelNext[i] && (holdCntNext[i] == HOLD_LAST) && (holdCnt[i] != HOLD_LAST);
      longSeenNext[i] = levelNext[i] &&
                        (longSeen[i] || (out_level[i] && holdCnt[i] == HOLD_LAST));
    end
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      sync1       <= '0;
      sync2       <= '0;
      out_level   <= '0;
      out_press   <= '0;
      out_release <= '0;
      out_long    <= '0;
      out_repeat  <= '0;
      longSeen    <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        dbCnt[i]   <= '0;
        holdCnt[i] <= '0;
      end
    end else begin
      sync1       <= in_btn;
      sync2       <= sync1;
      out_level   <= levelNext;
      out_press   <= levelNext & ~out_level;
      out_release <= ~levelNext & out_level;
      out_long    <= hit & ~longSeen;
      out_repeat  <= hit & longSeen & REPEAT_MASK;
      longSeen    <= longSeenNext;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        dbCnt[i]   <= dbCntNext[i];
        holdCnt[i] <= holdCntNext[i];
      end
    end
  end

endmodule

// File: tb/tb_washer_btn_conditioner.sv
// Scoreboard bench: expected pulse events are queued as pins are driven and
// matched against every pulse the conditioner emits.
module tb_washer_btn_conditioner;

  localparam int N = 5;

  typedef struct {
    int cycle;
    int ch;
    int kind;  // 0 press, 1 release, 2 long, 3 repeat
  } evT;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] level, press, rel, lng, rpt;

  int cyc;
  int nVec;
  int nErr;
  bit monEn;
  evT expQ[$];

  washer_btn_conditioner #(
    .N_BTN(5),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(5),
    .REPEAT_MASK(5'b10000)
  ) dut (
    .clk(clk),
    .in_reset(rst),
    .in_btn(btn),
    .out_level(level),
    .out_press(press),
    .out_release(rel),
    .out_long(lng),
    .out_repeat(rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] enc(input int c, input int ch, input int k);
    return {32'(c), 16'(ch), 16'(k)};
  endfunction

  task automatic push(input int c, input int ch, input int k);
    evT e;
    e.cycle = c;
    e.ch    = ch;
    e.kind  = k;
    expQ.push_back(e);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic logic [N-1:0] pulses(input int k);
    case (k)
      0:       return press;
      1:       return rel;
      2:       return lng;
      default: return rpt;
    endcase
  endfunction

  always @(negedge clk) begin
    if (monEn) begin
      for (int ch = 0; ch < N; ch++) begin
        for (int k = 0; k < 4; k++) begin
          logic [N-1:0] p;
          p = pulses(k);
          if (p[ch] === 1'b1) begin
            if (expQ.size() == 0) begin
              checkVal("spurious", enc(cyc, ch, k), '1);
            end else begin
              evT e;
              e = expQ.pop_front();
              checkVal("event", enc(cyc, ch, k), enc(e.cycle, e.ch, e.kind));
            end
          end
        end
      end
    end
  end

  initial begin
    int c;
    int p;
    int pat[6];
    nVec  = 0;
    nErr  = 0;
    monEn = 1'b0;
    btn   = '0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("resetOut", 64'({level, press, rel, lng, rpt}), 64'd0);
    rst   = 1'b0;
    monEn = 1'b1;
    @(negedge clk);

    // clean press and release on run, released before long
    c = cyc;
    btn[1] = 1'b1;
    push(c + 6, 1, 0);
    waitUntil(c + 5);
    checkVal("cleanLvlLow", 64'(level[1]), 64'd0);
    waitUntil(c + 6);
    checkVal("cleanLvlHigh", 64'(level[1]), 64'd1);
    waitUntil(c + 10);
    btn[1] = 1'b0;
    push(c + 16, 1, 1);
    waitUntil(c + 15);
    checkVal("relLvlHigh", 64'(level[1]), 64'd1);
    waitUntil(c + 16);
    checkVal("relLvlLow", 64'(level[1]), 64'd0);
    waitUntil(c + 22);
    checkVal("cleanLeftover", 64'(expQ.size()), 64'd0);

    // bounce on open
    c = cyc;
    pat = '{1, 0, 1, 1, 0, 1};
    push(c + 11, 3, 0);
    for (int i = 0; i < 6; i++) begin
      btn[3] = pat[i][0];
      @(negedge clk);
    end
    waitUntil(c + 10);
    checkVal("bounceLvlLow", 64'(level[3]), 64'd0);
    waitUntil(c + 11);
    checkVal("bounceLvlHigh", 64'(level[3]), 64'd1);
    waitUntil(c + 14);
    btn[3] = 1'b0;
    push(c + 20, 3, 1);
    waitUntil(c + 26);
    checkVal("bounceLeftover", 64'(expQ.size()), 64'd0);

    // three-cycle glitch on water
    c = cyc;
    btn[2] = 1'b1;
    waitUntil(c + 3);
    btn[2] = 1'b0;
    waitUntil(c + 8);
    checkVal("glitchLvlMid", 64'(level[2]), 64'd0);
    waitUntil(c + 14);
    checkVal("glitchLvlEnd", 64'(level[2]), 64'd0);
    checkVal("glitchLeftover", 64'(expQ.size()), 64'd0);

    // long press with auto-repeat on click
    c = cyc;
    p = c + 6;
    btn[4] = 1'b1;
    push(p, 4, 0);
    push(p + 19, 4, 2);
    push(p + 24, 4, 3);
    push(p + 29, 4, 3);
    push(p + 34, 4, 3);
    push(p + 39, 4, 3);
    push(p + 42, 4, 1);
    waitUntil(p + 36);
    btn[4] = 1'b0;
    waitUntil(p + 41);
    checkVal("longLvlHeld", 64'(level[4]), 64'd1);
    waitUntil(p + 50);
    checkVal("repeatLeftover", 64'(expQ.size()), 64'd0);

    // same hold on run: long only, no repeat
    c = cyc;
    p = c + 6;
    btn[1] = 1'b1;
    push(p, 1, 0);
    push(p + 19, 1, 2);
    push(p + 42, 1, 1);
    waitUntil(p + 36);
    btn[1] = 1'b0;
    waitUntil(p + 50);
    checkVal("longNoRepLeftover", 64'(expQ.size()), 64'd0);

    // reset while click is held
    c = cyc;
    btn[4] = 1'b1;
    push(c + 6, 4, 0);
    waitUntil(c + 10);
    checkVal("preRstLvl", 64'(level[4]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkVal("midRstOut", 64'({level, press, rel, lng, rpt}), 64'd0);
    push(c + 17, 4, 0);
    waitUntil(c + 16);
    checkVal("postRstLvlLow", 64'(level[4]), 64'd0);
    waitUntil(c + 20);
    btn[4] = 1'b0;
    push(c + 26, 4, 1);
    waitUntil(c + 32);
    checkVal("rstLeftover", 64'(expQ.size()), 64'd0);

    // simultaneous power and click
    c = cyc;
    btn[0] = 1'b1;
    btn[4] = 1'b1;
    push(c + 6, 0, 0);
    push(c + 6, 4, 0);
    waitUntil(c + 10);
    btn[0] = 1'b0;
    btn[4] = 1'b0;
    push(c + 16, 0, 1);
    push(c + 16, 4, 1);
    waitUntil(c + 22);
    checkVal("simulLeftover", 64'(expQ.size()), 64'd0);
    checkVal("finalLevel", 64'(level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
